apb_coef_regfile: RTL and testbench
===================================

# apb_coef_regfile

APB slave register bank that receives the coefficient writes issued by `apb_master` and holds every programmable coefficient of the image filter: CSC, filter1, filter2, inverse CSC, and bypass. Writes land in a shadow bank. A software commit plus a frame-sync pulse copies the shadow bank atomically into the active bank that drives the datapath, so coefficients never change mid-frame. The block sits inside `rtl_top`, directly downstream of `apb_master`, and runs entirely in the `clk_apb` domain.

## Interface
- `ADDR_WIDTH`, 10: APB byte address width.
- `COEF_WIDTH`, 12: signed coefficient width, two's complement.
- `FRAC_BITS`, 8: fractional bits of a coefficient; 1.0 = `1<<FRAC_BITS`.

- `clk_apb`  in  1  APB clock.
- `rstn_apb`  in  1  reset, asynchronous, active-high.
- `i_apb_paddr`  in  ADDR_WIDTH  APB address.
- `i_apb_psel`  in  1  select.
- `i_apb_penable`  in  1  enable.
- `i_apb_pwrite`  in  1  direction; 1 = write.
- `i_apb_pwdata`  in  32  write data.
- `o_apb_pready`  out  1  constant 1 (zero wait states).
- `o_apb_pslverr`  out  1  error response during an access phase.
- `i_frame_sync`  in  1  one-cycle pulse per frame, already synchronized to `clk_apb`.
- `o_csc_coef`  out  9*COEF_WIDTH  active CSC matrix, index k at bits [k*COEF_WIDTH +: COEF_WIDTH].
- `o_csc_offset`  out  3*COEF_WIDTH  active CSC offsets.
- `o_f1_coef`  out  9*COEF_WIDTH  active filter1 taps.
- `o_f2_coef`  out  9*COEF_WIDTH  active filter2 taps.
- `o_icsc_coef`  out  9*COEF_WIDTH  active inverse CSC matrix.
- `o_icsc_offset`  out  3*COEF_WIDTH  active inverse CSC offsets.
- `o_bypass`  out  1  active bypass flag.
- `o_update`  out  1  one-cycle pulse when the active bank is reloaded.
- `o_pending`  out  1  commit armed, waiting for a frame sync.
- `o_proto_err`  out  1  sticky APB protocol-error flag.

## Operation
- **Address map.** Byte addresses; word k sits at base + 4k.
  - CTRL 0x000: bit0 commit (write-1 arms), bit1 bypass (shadowed), bit2 write-1 clears `o_proto_err`.
  - CSC coef: 0x040 to 0x060, k = 0..8.
  - CSC offset: 0x064 to 0x06C.
  - Filter1: 0x080 to 0x0A0.
  - Filter2: 0x0C0 to 0x0E0.
  - ICSC coef: 0x100 to 0x120.
  - ICSC offset: 0x124 to 0x12C.
- **Write data.** A coefficient register stores `PWDATA[COEF_WIDTH-1:0]`; upper bits are ignored.
- **APB FSM** with states IDLE, SETUP, ACCESS:
  - IDLE to SETUP on `psel & !penable`.
  - SETUP to ACCESS on `psel & penable`.
  - ACCESS to SETUP on `psel & !penable` (back-to-back transfer), otherwise ACCESS to IDLE.
- **Write commit.** A write takes effect at the clock edge that ends ACCESS, when `pwrite=1`.
  - Reads are unsupported: read accesses complete with no effect and no error.
- **Protocol error.** `penable=1` while in IDLE, or `psel` dropping during SETUP:
  - sets `o_proto_err`;
  - moves the FSM to IDLE;
  - writes nothing.
- **Slave error.** `o_apb_pslverr`=1 during ACCESS when the address is unmapped or `paddr[1:0]≠0`. The write is discarded.
- **Commit.** Writing CTRL bit0=1 sets `pending`.
  - On `i_frame_sync` with `pending`=1, all shadow registers (including bypass) copy into the active bank, `pending` clears, and `o_update` pulses.
- **Reset values** (shadow and active banks alike):
  - CSC and ICSC matrices are identity: k = 0, 4, 8 hold 0x100; the rest hold 0.
  - Offsets are 0.
  - Filter taps are 0 except the center tap k=4, which holds 0x100.
  - `o_bypass`, `o_update`, `o_pending`, `o_proto_err`, `o_apb_pslverr` are 0.
  - `o_apb_pready` is 1.
  - FSM state is IDLE.

## Timing
- **Shadow write latency.** The shadow register updates at the edge ending ACCESS.
- **Commit latency.**
  - `pending` rises on the edge ending the CTRL ACCESS.
  - Active outputs and `o_update`=1 appear one edge after the first sampled `i_frame_sync` with `pending` high.
- **Commit write coinciding with frame sync.** The sync is ignored (`pending` was 0); the transfer waits for the next sync.
- **Shadow write coinciding with transfer.** The active bank receives the pre-write shadow value; the shadow keeps the new value.
- **Clear coinciding with error.** Error has priority over the CTRL bit2 clear in the same cycle.
- **Reset mid-transfer.** Everything returns to reset values immediately; `pending` is lost.

## Test plan
- **Reset defaults.** Hold `rstn_apb`=1, then release -> `o_csc_coef` k0 = 0x100, k1 = 0, `o_f1_coef` k4 = 0x100, all flags 0.
- **Shadow isolation.** Write 0x0FFF_F80 to 0x044, then pulse `i_frame_sync` without a commit -> `o_csc_coef` k1 stays 0.
- **Commit.** Write CTRL = 0x3, then pulse sync -> one cycle later `o_csc_coef` k1 = 0xF80, `o_bypass`=1, `o_update` high for exactly 1 cycle, `o_pending` drops 1→0.
- **Simultaneous commit and sync.** Commit write and sync in the same cycle -> no update; the next sync updates.
- **Slave error.** Write to 0x0F0 and to 0x042 -> `o_apb_pslverr`=1 in ACCESS, no register changes.
- **Protocol error.** Drive `penable`=1 from IDLE -> `o_proto_err`=1; writing CTRL 0x4 clears it; back-to-back writes to 0x080 and 0x084 with no IDLE cycle both land.

Source files
------------

// File: rtl/apb_coef_regfile.sv
// apb_coef_regfile
// APB slave register bank holding every programmable coefficient of the image
// filter. Writes land in a shadow bank; a software commit (CTRL bit0) followed
// by a frame-sync pulse copies the whole shadow bank, bypass flag included,
// into the active bank that drives the datapath.
//
// Ports:
//   clk_apb, rstn_apb          APB clock, asynchronous active-high reset
//   i_apb_*                    APB slave request (paddr/psel/penable/pwrite/pwdata)
//   o_apb_pready/o_apb_pslverr zero-wait-state ready, slave error in ACCESS
//   i_frame_sync               one-cycle frame pulse (clk_apb domain)
//   o_csc_coef/o_csc_offset    active CSC matrix and offsets
//   o_f1_coef/o_f2_coef        active filter1/filter2 taps
//   o_icsc_coef/o_icsc_offset  active inverse CSC matrix and offsets
//   o_bypass                   active bypass flag
//   o_update                   one-cycle pulse when the active bank reloads
//   o_pending                  commit armed, waiting for frame sync
//   o_proto_err                sticky APB protocol-error flag
module apb_coef_regfile #(
  parameter int ADDR_WIDTH = 10,
  parameter int COEF_WIDTH = 12,
  parameter int FRAC_BITS  = 8
) (
  input  logic                    clk_apb,
  input  logic                    rstn_apb,
  input  logic [ADDR_WIDTH-1:0]   i_apb_paddr,
  input  logic                    i_apb_psel,
  input  logic                    i_apb_penable,
  input  logic                    i_apb_pwrite,
  input  logic [31:0]             i_apb_pwdata,
  output logic                    o_apb_pready,
  output logic                    o_apb_pslverr,
  input  logic                    i_frame_sync,
  output logic [9*COEF_WIDTH-1:0] o_csc_coef,
  output logic [3*COEF_WIDTH-1:0] o_csc_offset,
  output logic [9*COEF_WIDTH-1:0] o_f1_coef,
  output logic [9*COEF_WIDTH-1:0] o_f2_coef,
  output logic [9*COEF_WIDTH-1:0] o_icsc_coef,
  output logic [3*COEF_WIDTH-1:0] o_icsc_offset,
  output logic                    o_bypass,
  output logic                    o_update,
  output logic                    o_pending,
  output logic                    o_proto_err
);

  // Flat register index: csc 0-8, csc_off 9-11, f1 12-20, f2 21-29,
  // icsc 30-38, icsc_off 39-41.
  localparam int unsigned NREG = 42;
  localparam logic [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << FRAC_BITS;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  function automatic logic [COEF_WIDTH-1:0] reset_val(input int unsigned idx);
    case (idx)
      // identity diagonals of CSC/ICSC, center taps of both filters
      0, 4, 8, 16, 25, 30, 34, 38: reset_val = COEF_ONE;
      default:                     reset_val = '0;
    endcase
  endfunction

  state_t                state;
  logic [COEF_WIDTH-1:0] shadow [NREG];
  logic [COEF_WIDTH-1:0] active [NREG];
  logic                  shadow_bypass;
  logic                  active_bypass;
  logic                  pending;
  logic                  update;
  logic                  proto_err;
  logic                  slverr;

  // Access captured on entry to ACCESS; applied at the edge that ends it.
  logic                  acc_we;
  logic                  acc_ctrl;
  logic [5:0]            acc_idx;
  logic [COEF_WIDTH-1:0] acc_data;

  logic                  dec_hit;
  logic                  dec_ctrl;
  logic [5:0]            dec_idx;
  int unsigned           word;
  logic                  commit_wr;

  logic                  unused_pwdata;
  assign unused_pwdata = ^i_apb_pwdata[31:COEF_WIDTH];

  // Word-address decode; CSC and ICSC offsets directly follow their matrices.
  always_comb begin
    word     = 32'(i_apb_paddr[ADDR_WIDTH-1:2]);
    dec_hit  = 1'b0;
    dec_ctrl = 1'b0;
    dec_idx  = '0;
    if (i_apb_paddr[1:0] == 2'b00) begin
      if (word == 0) begin
        dec_hit  = 1'b1;
        dec_ctrl = 1'b1;
      end else if (word >= 16 && word <= 27) begin
        dec_hit = 1'b1;
        dec_idx = 6'(word - 16);
      end else if (word >= 32 && word <= 40) begin
        dec_hit = 1'b1;
        dec_idx = 6'(word - 32 + 12);
      end else if (word >= 48 && word <= 56) begin
        dec_hit = 1'b1;
        dec_idx = 6'(word - 48 + 21);
      end else if (word >= 64 && word <= 75) begin
        dec_hit = 1'b1;
        dec_idx = 6'(word - 64 + 30);
      end
    end
  end

  assign commit_wr = (state == ACCESS) && acc_we && acc_ctrl && acc_data[0];

  always_ff @(posedge clk_apb or posedge rstn_apb) begin
    if (rstn_apb) begin
      state         <= IDLE;
      acc_we        <= 1'b0;
      acc_ctrl      <= 1'b0;
      acc_idx       <= '0;
      acc_data      <= '0;
      slverr        <= 1'b0;
      proto_err     <= 1'b0;
      pending       <= 1'b0;
      update        <= 1'b0;
      shadow_bypass <= 1'b0;
      active_bypass <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        shadow[i] <= reset_val(i);
        active[i] <= reset_val(i);
      end
    end else begin
      update <= 1'b0;
      slverr <= 1'b0;

      // Transfer reads the shadow as it was before any write at this edge;
      // a commit landing now re-arms rather than being consumed.
      if (i_frame_sync && pending) begin
        for (int unsigned i = 0; i < NREG; i++) active[i] <= shadow[i];
        active_bypass <= shadow_bypass;
        update        <= 1'b1;
      end
      pending <= commit_wr | (pending & ~i_frame_sync);

      case (state)
        IDLE: begin
          if (i_apb_penable) proto_err <= 1'b1;
          else if (i_apb_psel) state <= SETUP;
        end
        SETUP: begin
          if (!i_apb_psel) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (i_apb_penable) begin
            state    <= ACCESS;
            acc_we   <= i_apb_pwrite & dec_hit;
            acc_ctrl <= dec_ctrl;
            acc_idx  <= dec_idx;
            acc_data <= i_apb_pwdata[COEF_WIDTH-1:0];
            slverr   <= i_apb_pwrite & ~dec_hit;
          end
        end
        ACCESS: begin
          state <= (i_apb_psel && !i_apb_penable) ? SETUP : IDLE;
          if (acc_we) begin
            if (acc_ctrl) begin
              shadow_bypass <= acc_data[1];
              if (acc_data[2]) proto_err <= 1'b0;
            end else begin
              shadow[acc_idx] <= acc_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_csc_coef    = '0;
    o_csc_offset  = '0;
    o_f1_coef     = '0;
    o_f2_coef     = '0;
    o_icsc_coef   = '0;
    o_icsc_offset = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      o_csc_coef[k*COEF_WIDTH +: COEF_WIDTH]  = active[k];
      o_f1_coef[k*COEF_WIDTH +: COEF_WIDTH]   = active[12+k];
      o_f2_coef[k*COEF_WIDTH +: COEF_WIDTH]   = active[21+k];
      o_icsc_coef[k*COEF_WIDTH +: COEF_WIDTH] = active[30+k];
    end
    for (int unsigned k = 0; k < 3; k++) begin
      o_csc_offset[k*COEF_WIDTH +: COEF_WIDTH]  = active[9+k];
      o_icsc_offset[k*COEF_WIDTH +: COEF_WIDTH] = active[39+k];
    end
  end

  assign o_apb_pready  = 1'b1;
  assign o_apb_pslverr = slverr;
  assign o_bypass      = active_bypass;
  assign o_update      = update;
  assign o_pending     = pending;
  assign o_proto_err   = proto_err;

endmodule

// File: tb/tb_apb_coef_regfile.sv
// Self-checking bench for apb_coef_regfile: directed scenarios plus random
// APB traffic against a region/word-level reference model of the shadow and
// active banks, compared on every falling clock edge.
module tb_apb_coef_regfile;
  localparam int AW = 10;
  localparam int CW = 12;

  logic          clk_apb = 1'b0;
  logic          rstn_apb;
  logic [AW-1:0] i_apb_paddr;
  logic          i_apb_psel, i_apb_penable, i_apb_pwrite;
  logic [31:0]   i_apb_pwdata;
  logic          o_apb_pready, o_apb_pslverr;
  logic          i_frame_sync;
  logic [9*CW-1:0] o_csc_coef, o_f1_coef, o_f2_coef, o_icsc_coef;
  logic [3*CW-1:0] o_csc_offset, o_icsc_offset;
  logic          o_bypass, o_update, o_pending, o_proto_err;

  always #5 clk_apb = ~clk_apb;

  apb_coef_regfile #(.ADDR_WIDTH(AW), .COEF_WIDTH(CW), .FRAC_BITS(8)) dut (
    .clk_apb(clk_apb), .rstn_apb(rstn_apb),
    .i_apb_paddr(i_apb_paddr), .i_apb_psel(i_apb_psel),
    .i_apb_penable(i_apb_penable), .i_apb_pwrite(i_apb_pwrite),
    .i_apb_pwdata(i_apb_pwdata), .o_apb_pready(o_apb_pready),
    .o_apb_pslverr(o_apb_pslverr), .i_frame_sync(i_frame_sync),
    .o_csc_coef(o_csc_coef), .o_csc_offset(o_csc_offset),
    .o_f1_coef(o_f1_coef), .o_f2_coef(o_f2_coef),
    .o_icsc_coef(o_icsc_coef), .o_icsc_offset(o_icsc_offset),
    .o_bypass(o_bypass), .o_update(o_update),
    .o_pending(o_pending), .o_proto_err(o_proto_err)
  );

  // Regions: 0 csc, 1 csc_off, 2 f1, 3 f2, 4 icsc, 5 icsc_off
  int unsigned REG_CNT  [6] = '{9, 3, 9, 9, 9, 3};
  int unsigned REG_BASE [6] = '{'h040, 'h064, 'h080, 'h0C0, 'h100, 'h124};

  logic [CW-1:0] m_sh  [6][9];
  logic [CW-1:0] m_act [6][9];
  logic m_sh_byp, m_act_byp, m_pend, m_perr, m_upd, m_slverr;

  // stimulus-side event flags consumed by cyc()
  logic          sync_req, rand_sync, land_v, perr_next, slverr_next, chk_en;
  logic [AW-1:0] land_a;
  logic [31:0]   land_d;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
  endtask

  function automatic logic [CW-1:0] rst_val(input int r, input int k);
    if (r == 0 || r == 4) return (k == 0 || k == 4 || k == 8) ? 12'h100 : 12'h000;
    if (r == 2 || r == 3) return (k == 4) ? 12'h100 : 12'h000;
    return 12'h000;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 9; k++) begin
        m_sh[r][k]  = rst_val(r, k);
        m_act[r][k] = rst_val(r, k);
      end
    m_sh_byp = 0; m_act_byp = 0; m_pend = 0; m_perr = 0; m_upd = 0; m_slverr = 0;
  endtask

  function automatic bit lookup(input logic [AW-1:0] a, output int r, output int k);
    int unsigned ai;
    ai = int'(a);
    r = 0; k = 0;
    if (ai % 4 != 0) return 0;
    for (int i = 0; i < 6; i++)
      if (ai >= REG_BASE[i] && ai < REG_BASE[i] + 4 * REG_CNT[i]) begin
        r = i; k = int'((ai - REG_BASE[i]) / 4);
        return 1;
      end
    return 0;
  endfunction

  function automatic bit is_mapped(input logic [AW-1:0] a);
    int r, k;
    return (a == '0) || lookup(a, r, k);
  endfunction

  // One clock: drive frame sync, wait for the edge, then apply to the model
  // every event the edge carried (transfer first, then the landing write).
  task automatic cyc();
    logic s, lv, ps, sv;
    logic [AW-1:0] la;
    logic [31:0] ld;
    int r, k;
    s = sync_req || (rand_sync && $urandom_range(0, 5) == 0);
    i_frame_sync = s;
    sync_req = 0;
    lv = land_v; la = land_a; ld = land_d; ps = perr_next; sv = slverr_next;
    land_v = 0; perr_next = 0; slverr_next = 0;
    @(posedge clk_apb); #1;
    if (!rstn_apb) begin
      m_upd = 0;
      if (s && m_pend) begin
        m_act = m_sh;
        m_act_byp = m_sh_byp;
        m_pend = 0;
        m_upd = 1;
      end
      if (lv) begin
        if (la == '0) begin
          m_sh_byp = ld[1];
          if (ld[0]) m_pend = 1;
          if (ld[2]) m_perr = 0;
        end else if (lookup(la, r, k)) begin
          m_sh[r][k] = ld[CW-1:0];
        end
      end
      if (ps) m_perr = 1;
      m_slverr = sv;
    end
  endtask

  task automatic idle(input int n);
    i_apb_psel = 0; i_apb_penable = 0;
    repeat (n) cyc();
  endtask

  // Setup + access phases; the write lands on the following edge.
  task automatic apb_xfer(input logic [AW-1:0] a, input logic [31:0] d, input logic wr);
    i_apb_psel = 1; i_apb_penable = 0; i_apb_paddr = a; i_apb_pwdata = d; i_apb_pwrite = wr;
    cyc();
    i_apb_penable = 1;
    slverr_next = wr && !is_mapped(a);
    cyc();
    if (wr) begin land_v = 1; land_a = a; land_d = d; end
  endtask

  task automatic proto_idle();
    idle(1);
    i_apb_psel = 1'($urandom); i_apb_penable = 1; perr_next = 1;
    cyc();
    i_apb_psel = 0; i_apb_penable = 0;
  endtask

  task automatic proto_setup();
    i_apb_psel = 1; i_apb_penable = 0; i_apb_pwrite = 1;
    i_apb_paddr = 10'h044; i_apb_pwdata = $urandom;
    cyc();
    i_apb_psel = 0; i_apb_penable = 1'($urandom); perr_next = 1;
    cyc();
    i_apb_penable = 0;
  endtask

  always @(negedge clk_apb) begin
    logic [127:0] e [6];
    if (chk_en) begin
      for (int r = 0; r < 6; r++) begin
        e[r] = '0;
        for (int k = 0; k < int'(REG_CNT[r]); k++) e[r][k*CW +: CW] = m_act[r][k];
      end
      check("csc_coef",    128'(o_csc_coef),    e[0]);
      check("csc_offset",  128'(o_csc_offset),  e[1]);
      check("f1_coef",     128'(o_f1_coef),     e[2]);
      check("f2_coef",     128'(o_f2_coef),     e[3]);
      check("icsc_coef",   128'(o_icsc_coef),   e[4]);
      check("icsc_offset", 128'(o_icsc_offset), e[5]);
      check("flags", 128'({o_apb_pready, o_apb_pslverr, o_bypass, o_update, o_pending, o_proto_err}),
            128'({1'b1, m_slverr, m_act_byp, m_upd, m_pend, m_perr}));
    end
  end

  initial begin
    int r, k, op;
    logic [AW-1:0] a;
    model_reset();
    rstn_apb = 1; i_apb_paddr = '0; i_apb_psel = 0; i_apb_penable = 0;
    i_apb_pwrite = 0; i_apb_pwdata = '0; i_frame_sync = 0;
    sync_req = 0; rand_sync = 0; land_v = 0; land_a = '0; land_d = '0;
    perr_next = 0; slverr_next = 0; chk_en = 1;
    repeat (2) @(posedge clk_apb);
    #1 rstn_apb = 0;

    // reset defaults
    check("rst_csc_k0", 128'(o_csc_coef[11:0]), 128'(12'h100));
    check("rst_csc_k1", 128'(o_csc_coef[23:12]), 128'(12'h000));
    check("rst_f1_k4",  128'(o_f1_coef[4*CW +: CW]), 128'(12'h100));
    check("rst_flags",  128'({o_bypass, o_update, o_pending, o_proto_err, o_apb_pslverr}), 128'(0));

    // shadow isolation: sync without commit leaves active untouched
    apb_xfer(10'h044, 32'h0FFFF80, 1);
    idle(1);
    sync_req = 1; cyc(); cyc();
    check("iso_csc_k1", 128'(o_csc_coef[23:12]), 128'(12'h000));

    // commit then sync
    apb_xfer(10'h000, 32'h3, 1);
    idle(1);
    check("commit_pending", 128'(o_pending), 128'(1));
    sync_req = 1; cyc();
    check("commit_csc_k1", 128'(o_csc_coef[23:12]), 128'(12'hF80));
    check("commit_bypass", 128'(o_bypass), 128'(1));
    check("commit_update", 128'(o_update), 128'(1));
    check("commit_pend_clr", 128'(o_pending), 128'(0));
    cyc();
    check("update_one_cycle", 128'(o_update), 128'(0));

    // commit landing on the same edge as a sync: that sync is ignored
    apb_xfer(10'h048, 32'h123, 1);
    apb_xfer(10'h000, 32'h1, 1);
    sync_req = 1; idle(1);
    check("simul_no_update", 128'(o_update), 128'(0));
    check("simul_pending", 128'(o_pending), 128'(1));
    sync_req = 1; cyc();
    check("simul_next_sync", 128'(o_csc_coef[35:24]), 128'(12'h123));

    // slave errors: unmapped and misaligned
    apb_xfer(10'h0F0, 32'h555, 1);
    check("slverr_unmapped", 128'(o_apb_pslverr), 128'(1));
    apb_xfer(10'h042, 32'h666, 1);
    check("slverr_misalign", 128'(o_apb_pslverr), 128'(1));
    idle(1);

    // protocol error, clear, back-to-back writes
    proto_idle();
    check("proto_set", 128'(o_proto_err), 128'(1));
    apb_xfer(10'h000, 32'h4, 1);
    idle(1);
    check("proto_clear", 128'(o_proto_err), 128'(0));
    apb_xfer(10'h080, 32'h011, 1);
    apb_xfer(10'h084, 32'h022, 1);
    apb_xfer(10'h000, 32'h1, 1);
    idle(1);
    sync_req = 1; cyc();
    check("b2b_f1_k0", 128'(o_f1_coef[11:0]), 128'(12'h011));
    check("b2b_f1_k1", 128'(o_f1_coef[23:12]), 128'(12'h022));

    // random traffic with random frame syncs
    rand_sync = 1;
    repeat (400) begin
      op = $urandom_range(0, 19);
      if (op < 11) begin
        r = $urandom_range(0, 5);
        k = $urandom_range(0, REG_CNT[r] - 1);
        apb_xfer(10'(REG_BASE[r] + 4 * k), $urandom, 1);
      end else if (op < 14) apb_xfer(10'h000, 32'($urandom_range(0, 7)), 1);
      else if (op < 15) apb_xfer(10'($urandom), $urandom, 1);
      else if (op < 16) begin
        a = 10'($urandom);
        apb_xfer(a, $urandom, 0);
      end else if (op < 17) proto_idle();
      else if (op < 18) proto_setup();
      else idle($urandom_range(1, 3));
    end
    idle(2);

    // reset in the middle of a transfer with a commit armed
    rand_sync = 0;
    apb_xfer(10'h000, 32'h1, 1);
    apb_xfer(10'h040, 32'h777, 1);
    rstn_apb = 1;
    land_v = 0;
    model_reset();
    #1;
    check("midrst_pending", 128'(o_pending), 128'(0));
    check("midrst_csc_k0", 128'(o_csc_coef[11:0]), 128'(12'h100));
    i_apb_psel = 0; i_apb_penable = 0;
    cyc(); cyc();
    rstn_apb = 0;
    idle(2);
    sync_req = 1; cyc(); cyc();
    check("midrst_no_update", 128'(o_csc_coef[11:0]), 128'(12'h100));

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
